multi_cook_timer: RTL and testbench

Parametrised N-channel countdown timer, the multi-channel successor of the single cook timer. It sits between the button edge detectors (`button_cntr`) and the FND display driver (`FND_cntr`). Each channel independently holds and counts down a min:sec value, with pause/resume, clear and per-channel alarm with auto-off. One channel at a time is selected for editing and display; the selected channel's time is output as 4-digit BCD.

---
 rtl/timer_pkg.sv | 16 +
 rtl/bin_to_dec.sv | 17 +
 rtl/timer_channel.sv | 117 +++++++++++
 rtl/multi_cook_timer.sv | 94 +++++++++
 tb/tb_multi_cook_timer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the multi-channel cook timer.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } ch_state_t;

  localparam int SEC_MAX = 59;
  localparam int SEC_W   = 6;
  localparam int MIN_W   = 7;
  localparam int BCD_W   = 16;

endpackage

// File: rtl/bin_to_dec.sv
// Binary 0..99 to two packed BCD digits {tens, ones}.
module bin_to_dec (
  input  logic [6:0] bin,
  output logic [7:0] bcd
);

  logic [3:0] tens;

  always_comb begin
    tens = 4'd0;
    for (int i = 1; i < 10; i++) begin
      if (bin >= 7'(i * 10)) tens = 4'(i);
    end
    bcd = {tens, 4'(bin - 7'(tens) * 7'd10)};
  end

endmodule

// File: rtl/timer_channel.sv
// One countdown channel: min:sec value, IDLE/RUN/PAUSE/ALARM state and alarm auto-off counter.
module timer_channel
  import timer_pkg::*;
#(
  parameter int MAX_MIN       = 99,
  parameter int ALARM_TIMEOUT = 30
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             start,
  input  logic             inc_sec,
  input  logic             inc_min,
  input  logic             off,
  input  logic             ack,
  output logic [MIN_W-1:0] min,
  output logic [SEC_W-1:0] sec,
  output ch_state_t        state
);

  localparam int ACNT_W = $clog2(ALARM_TIMEOUT + 1);

  ch_state_t         state_q, state_d;
  logic [MIN_W-1:0]  min_q, min_d, min_inc, min_dec;
  logic [SEC_W-1:0]  sec_q, sec_d, sec_inc, sec_dec;
  logic [ACNT_W-1:0] acnt_q, acnt_d;

  always_comb begin
    min_inc = (min_q == 7'(MAX_MIN)) ? '0 : min_q + 7'd1;
    sec_inc = (sec_q == 6'(SEC_MAX)) ? '0 : sec_q + 6'd1;
    if (sec_q != '0) begin
      min_dec = min_q;
      sec_dec = sec_q - 6'd1;
    end else begin
      min_dec = min_q - 7'd1;
      sec_dec = 6'(SEC_MAX);
    end

    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    acnt_d  = acnt_q;

    if (off || (ack && state_q == ST_ALARM)) begin
      state_d = ST_IDLE;
      min_d   = '0;
      sec_d   = '0;
      acnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (min_q != '0 || sec_q != '0) state_d = ST_RUN;
          end else if (inc_min) begin
            min_d = min_inc;
          end else if (inc_sec) begin
            sec_d = sec_inc;
          end
        end
        ST_PAUSE: begin
          // An edit that wraps the value to 00:00 leaves nothing to resume.
          if (start) begin
            state_d = ST_RUN;
          end else if (inc_min) begin
            min_d = min_inc;
            if (min_inc == '0 && sec_q == '0) state_d = ST_IDLE;
          end else if (inc_sec) begin
            sec_d = sec_inc;
            if (min_q == '0 && sec_inc == '0) state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (start) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            min_d = min_dec;
            sec_d = sec_dec;
            if (min_dec == '0 && sec_dec == '0) begin
              state_d = ST_ALARM;
              acnt_d  = '0;
            end
          end
        end
        ST_ALARM: begin
          if (tick) begin
            if (acnt_q == ACNT_W'(ALARM_TIMEOUT - 1)) begin
              state_d = ST_IDLE;
              acnt_d  = '0;
            end else begin
              acnt_d = acnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      min_q   <= '0;
      sec_q   <= '0;
      acnt_q  <= '0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      acnt_q  <= acnt_d;
    end
  end

  assign min   = min_q;
  assign sec   = sec_q;
  assign state = state_q;

endmodule

// File: rtl/multi_cook_timer.sv
// N-channel cook timer: shared 1 s prescaler, channel select, button demux and BCD display of the selected channel.
module multi_cook_timer
  import timer_pkg::*;
#(
  parameter int CH_NUM        = 4,
  parameter int TICK_DIV      = 100_000_000,
  parameter int MAX_MIN       = 99,
  parameter int ALARM_TIMEOUT = 30
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      btn_start,
  input  logic                      btn_inc_sec,
  input  logic                      btn_inc_min,
  input  logic                      btn_sel,
  input  logic                      btn_off,
  output logic [$clog2(CH_NUM)-1:0] sel,
  output logic [BCD_W-1:0]          disp_bcd,
  output logic [CH_NUM-1:0]         running,
  output logic [CH_NUM-1:0]         alarm,
  output logic                      alarm_any
);

  localparam int SEL_W = $clog2(CH_NUM);
  localparam int PRE_W = $clog2(TICK_DIV);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [BCD_W-1:0] disp_q, disp_d;
  logic             tick;

  logic [MIN_W-1:0] ch_min [CH_NUM];
  logic [SEC_W-1:0] ch_sec [CH_NUM];
  ch_state_t        ch_state [CH_NUM];
  logic [7:0]       min_bcd, sec_bcd;

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
      logic hit;
      // Local buttons target the pre-update selection; alarm acknowledge is broadcast.
      assign hit = (sel_q == SEL_W'(gi));

      timer_channel #(
        .MAX_MIN      (MAX_MIN),
        .ALARM_TIMEOUT(ALARM_TIMEOUT)
      ) u_ch (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (tick),
        .start  (btn_start & hit),
        .inc_sec(btn_inc_sec & hit),
        .inc_min(btn_inc_min & hit),
        .off    (btn_off & ~alarm_any & hit),
        .ack    (btn_off & alarm_any),
        .min    (ch_min[gi]),
        .sec    (ch_sec[gi]),
        .state  (ch_state[gi])
      );

      assign running[gi] = (ch_state[gi] == ST_RUN);
      assign alarm[gi]   = (ch_state[gi] == ST_ALARM);
    end
  endgenerate

  assign alarm_any = |alarm;

  bin_to_dec u_min_bcd (.bin(ch_min[sel_q]),         .bcd(min_bcd));
  bin_to_dec u_sec_bcd (.bin({1'b0, ch_sec[sel_q]}), .bcd(sec_bcd));

  always_comb begin
    tick   = (pre_q == PRE_W'(TICK_DIV - 1));
    pre_d  = tick ? '0 : pre_q + 1'b1;
    sel_d  = sel_q;
    if (btn_sel) sel_d = (sel_q == SEL_W'(CH_NUM - 1)) ? '0 : sel_q + 1'b1;
    disp_d = {min_bcd, sec_bcd};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_q  <= '0;
      sel_q  <= '0;
      disp_q <= '0;
    end else begin
      pre_q  <= pre_d;
      sel_q  <= sel_d;
      disp_q <= disp_d;
    end
  end

  assign sel      = sel_q;
  assign disp_bcd = disp_q;

endmodule

// File: tb/tb_multi_cook_timer.sv
// Self-checking bench: per-cycle comparison against a seconds-level behavioural model plus literal checkpoints.
module tb_multi_cook_timer;

  localparam int CH  = 4;
  localparam int DIV = 4;
  localparam int TO  = 3;
  localparam int MX  = 99;

  localparam logic [4:0] NONE  = 5'b00000;
  localparam logic [4:0] ISEC  = 5'b00001;
  localparam logic [4:0] IMIN  = 5'b00010;
  localparam logic [4:0] START = 5'b00100;
  localparam logic [4:0] SELB  = 5'b01000;
  localparam logic [4:0] OFF   = 5'b10000;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ALARM = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        b_start = 1'b0, b_isec = 1'b0, b_imin = 1'b0, b_sel = 1'b0, b_off = 1'b0;
  logic [1:0]  sel;
  logic [15:0] disp_bcd;
  logic [3:0]  running, alarm;
  logic        alarm_any;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Model state
  int m_st [CH];
  int m_min [CH];
  int m_sec [CH];
  int m_acnt [CH];
  int m_sel;
  int edge_n;
  logic [15:0] m_disp;

  always #5 clk = ~clk;

  multi_cook_timer #(
    .CH_NUM(CH), .TICK_DIV(DIV), .MAX_MIN(MX), .ALARM_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_start(b_start), .btn_inc_sec(b_isec), .btn_inc_min(b_imin),
    .btn_sel(b_sel), .btn_off(b_off),
    .sel(sel), .disp_bcd(disp_bcd), .running(running), .alarm(alarm), .alarm_any(alarm_any)
  );

  function automatic logic [15:0] to_bcd(int mn, int sc);
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit tick, any_al, hit;
    int t;
    logic [15:0] nd;
    if (!reset_n) begin
      for (int i = 0; i < CH; i++) begin
        m_st[i] = M_IDLE; m_min[i] = 0; m_sec[i] = 0; m_acnt[i] = 0;
      end
      m_sel = 0; edge_n = 0; m_disp = 16'h0000;
      return;
    end
    tick = (edge_n % DIV == DIV - 1);
    edge_n++;
    any_al = 0;
    for (int i = 0; i < CH; i++) if (m_st[i] == M_ALARM) any_al = 1;
    nd = to_bcd(m_min[m_sel], m_sec[m_sel]);
    for (int i = 0; i < CH; i++) begin
      hit = (i == m_sel);
      if ((b_off && !any_al && hit) || (b_off && any_al && m_st[i] == M_ALARM)) begin
        m_st[i] = M_IDLE; m_min[i] = 0; m_sec[i] = 0; m_acnt[i] = 0;
      end else begin
        case (m_st[i])
          M_IDLE, M_PAUSE: begin
            if (hit && b_start) begin
              if (m_st[i] == M_PAUSE || m_min[i] * 60 + m_sec[i] != 0) m_st[i] = M_RUN;
            end else if (hit && (b_imin || b_isec)) begin
              if (b_imin) m_min[i] = (m_min[i] + 1) % (MX + 1);
              else        m_sec[i] = (m_sec[i] + 1) % 60;
              if (m_min[i] * 60 + m_sec[i] == 0) m_st[i] = M_IDLE;
            end
          end
          M_RUN: begin
            if (hit && b_start) m_st[i] = M_PAUSE;
            else if (tick) begin
              t = m_min[i] * 60 + m_sec[i] - 1;
              m_min[i] = t / 60;
              m_sec[i] = t % 60;
              if (t == 0) begin m_st[i] = M_ALARM; m_acnt[i] = 0; end
            end
          end
          default: begin
            if (tick) begin
              m_acnt[i]++;
              if (m_acnt[i] == TO) begin m_st[i] = M_IDLE; m_acnt[i] = 0; end
            end
          end
        endcase
      end
    end
    if (b_sel) m_sel = (m_sel + 1) % CH;
    m_disp = nd;
  endtask

  task automatic step(input logic [4:0] btn);
    {b_off, b_sel, b_start, b_imin, b_isec} = btn;
    @(posedge clk);
    model_step();
    #1;
    {b_off, b_sel, b_start, b_imin, b_isec} = NONE;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(NONE);
  endtask

  task automatic repeat_btn(input logic [4:0] btn, input int n);
    for (int i = 0; i < n; i++) step(btn);
  endtask

  // Idle until the next edge is the first of a prescaler period (ticks land on offsets 3, 7, 11, ...).
  task automatic align();
    while (edge_n % DIV != 0) step(NONE);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] er, ea;
      er = '0; ea = '0;
      for (int i = 0; i < CH; i++) begin
        er[i] = (m_st[i] == M_RUN);
        ea[i] = (m_st[i] == M_ALARM);
      end
      chk("cyc_sel", 32'(sel), 32'(m_sel));
      chk("cyc_disp", 32'(disp_bcd), 32'(m_disp));
      chk("cyc_running", 32'(running), 32'(er));
      chk("cyc_alarm", 32'(alarm), 32'(ea));
      chk("cyc_alarm_any", 32'(alarm_any), 32'(|ea));
    end
  end

  initial begin
    // 1. Reset
    reset_n = 1'b0;
    step(NONE); step(NONE);
    chk_en = 1;
    reset_n = 1'b1;
    chk("rst_disp", 32'(disp_bcd), 32'h0000);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_alarm", 32'(alarm), 0);
    chk("rst_running", 32'(running), 0);

    // 2. Basic countdown from 01:02
    step(IMIN); step(ISEC); step(ISEC);
    idle(2);
    chk("set_0102", 32'(disp_bcd), 32'h0102);
    align();
    step(START);
    chk("run0_on", 32'(running), 32'b0001);
    idle(250);
    chk("cd_alarm", 32'(alarm), 32'b0001);
    chk("cd_disp", 32'(disp_bcd), 32'h0000);
    chk("cd_running", 32'(running), 0);
    step(OFF);
    chk("ack_alarm", 32'(alarm), 0);

    // 3. Borrow and seconds wrap
    step(IMIN);
    align();
    step(START); idle(3); step(START);
    idle(2);
    chk("borrow_0059", 32'(disp_bcd), 32'h0059);
    chk("borrow_paused", 32'(running), 0);
    step(OFF);
    step(IMIN); repeat_btn(ISEC, 59); step(ISEC);
    idle(2);
    chk("sec_wrap_0100", 32'(disp_bcd), 32'h0100);
    step(OFF);

    // 4. Concurrent channels
    align();
    step(ISEC); step(ISEC); step(START); step(SELB);
    repeat_btn(ISEC, 5); step(START);
    idle(6);
    chk("conc_alarm", 32'(alarm), 32'b0001);
    chk("conc_running", 32'(running), 32'b0010);
    step(OFF);
    chk("conc_ack", 32'(alarm), 0);
    chk("conc_ch1_run", 32'(running), 32'b0010);
    step(START);
    idle(2);
    chk("conc_ch1_0003", 32'(disp_bcd), 32'h0003);
    chk("conc_sel", 32'(sel), 1);

    // 5. Auto-off, start at 00:00, start+tick
    align();
    step(SELB); step(ISEC); step(START);
    idle(12);
    chk("auto_alarm_on", 32'(alarm), 32'b0100);
    step(NONE);
    chk("auto_alarm_off", 32'(alarm), 0);
    chk("auto_idle", 32'(running), 0);
    step(START);
    chk("start_zero", 32'(running), 0);
    idle(2);
    chk("start_zero_disp", 32'(disp_bcd), 32'h0000);
    align();
    repeat_btn(ISEC, 10); step(START); step(START);
    chk("start_tick_pause", 32'(running), 0);
    idle(2);
    chk("start_tick_0010", 32'(disp_bcd), 32'h0010);
    idle(8);
    chk("pause_hold_0010", 32'(disp_bcd), 32'h0010);

    // 6. Reset mid-run at 00:30
    repeat_btn(ISEC, 20); step(START);
    chk("pre_rst_run", 32'(running), 32'b0100);
    reset_n = 1'b0;
    step(START);
    reset_n = 1'b1;
    chk("mid_rst_sel", 32'(sel), 0);
    chk("mid_rst_disp", 32'(disp_bcd), 32'h0000);
    chk("mid_rst_running", 32'(running), 0);
    chk("mid_rst_alarm", 32'(alarm), 0);
    chk("mid_rst_any", 32'(alarm_any), 0);
    idle(8);
    step(SELB); step(SELB);
    idle(2);
    chk("post_rst_ch2", 32'(disp_bcd), 32'h0000);
    chk("post_rst_sel", 32'(sel), 2);
    chk("post_rst_run", 32'(running), 0);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
